// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a single outstanding memory read
// and a 2-entry {pc, instr} output FIFO feeding the ID register.
//
// Ports
//   clk              single clock, rising edge
//   rst_n            synchronous active-low reset
//   redirect_i       flush + redirect (branch/jump resolution or trap)
//   redirect_pc_i    new fetch address, low two bits forced to zero
//   mem_req_valid_o  instruction read request valid
//   mem_req_ready_i  memory accepts the request
//   mem_req_addr_o   word-aligned request address (current fetch_pc)
//   mem_rsp_valid_i  read data valid (no back-pressure on responses)
//   mem_rsp_data_i   instruction word
//   out_valid_o      FIFO head valid towards ID
//   out_ready_i      ID accepts the head entry
//   out_pc_o         PC of the head entry
//   out_instr_o      instruction of the head entry
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [63:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_pc_o,
    output logic [31:0] out_instr_o
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [63:0] fifo_pc_q [2];
    logic [63:0] fifo_pc_d [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];

    logic        req_hs;
    logic        pop;
    logic        push;
    logic        wr_idx;

    // Redirect targets are always word aligned; the low bits are dropped.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Request valid is a function of state only (plus reset), never of redirect_i,
    // so a redirect cannot create a combinational path to the memory port.
    assign mem_req_valid_o = (state_q == ST_REQ) && (count_q != 2'd2) && rst_n;
    assign mem_req_addr_o  = fetch_pc_q;
    assign req_hs          = mem_req_valid_o && mem_req_ready_i;

    assign out_valid_o = (count_q != 2'd0) && rst_n;
    assign out_pc_o    = rst_n ? fifo_pc_q[rd_ptr_q]    : 64'd0;
    assign out_instr_o = rst_n ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign pop         = out_valid_o && out_ready_i;

    // A response that coincides with a redirect belongs to the flushed path.
    assign push   = (state_q == ST_WAIT) && mem_rsp_valid_i && !redirect_i;
    // A request is only issued with count<2, and at most one is in flight,
    // so a push never meets a full FIFO and the tail is head + count.
    assign wr_idx = rd_ptr_q ^ count_q[0];

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        if (req_hs) begin
            req_pc_d = fetch_pc_q;
        end

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[63:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            unique case (state_q)
                // A request accepted this cycle still has a response coming back.
                ST_REQ:  state_d = req_hs ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = mem_rsp_valid_i ? ST_REQ : ST_DROP;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    // Responses seen here are stale and ignored.
                    if (req_hs) begin
                        fetch_pc_d = fetch_pc_q + 64'd4;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (mem_rsp_valid_i) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase

            if (push) begin
                fifo_pc_d[wr_idx]    = req_pc_q;
                fifo_instr_d[wr_idx] = mem_rsp_data_i;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= {RESET_PC[63:2], 2'b00};
            req_pc_q   <= 64'd0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= 64'd0;
                fifo_instr_q[i] <= 32'd0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- directed self-checking bench for if_fetch.
// Inputs change on the falling edge; outputs are checked 1 ns later, well
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_pc_o;
    logic [31:0] out_instr_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    if_fetch #(.RESET_PC(BASE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_pc_o        (out_pc_o),
        .out_instr_o     (out_instr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
            $display("check %-16s observed=%h expected=%h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Set the per-cycle inputs, then settle for 1 ns before the checks.
    task automatic drive(input logic rst, input logic rdy, input logic rsp,
                         input logic [31:0] data, input logic ordy,
                         input logic redir, input logic [63:0] rpc);
        rst_n           = rst;
        mem_req_ready_i = rdy;
        mem_rsp_valid_i = rsp;
        mem_rsp_data_i  = data;
        out_ready_i     = ordy;
        redirect_i      = redir;
        redirect_pc_i   = rpc;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_reqv"}, 64'(mem_req_valid_o), 64'd0);
        chk({tag, "_outv"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_outpc"}, out_pc_o, 64'd0);
        chk({tag, "_outin"}, 64'(out_instr_o), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_reset_outputs(tag);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        next_cycle();
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        // ---- streaming: one request every 2 cycles, 1-cycle response latency
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
            chk("str_reqv", 64'(mem_req_valid_o), 64'd1);
            chk("str_addr", mem_req_addr_o, BASE + 64'(4 * k));
            if (k > 0) begin
                chk("str_outv", 64'(out_valid_o), 64'd1);
                chk("str_outpc", out_pc_o, BASE + 64'(4 * (k - 1)));
                chk("str_instr", 64'(out_instr_o), 64'h13);
            end else begin
                chk("str_outv0", 64'(out_valid_o), 64'd0);
            end
            next_cycle();
            drive(1'b1, 1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'd0);
            chk("str_wait_reqv", 64'(mem_req_valid_o), 64'd0);
            next_cycle();
        end

        // Reset with one entry still in the FIFO: outputs must read zero.
        do_reset("rst1");

        // ---- back-pressure: fill both entries, hold, then drain in order
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        chk("bp_addr0", mem_req_addr_o, BASE);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        chk("bp_addr1", mem_req_addr_o, BASE + 64'd4);
        chk("bp_head0", out_pc_o, BASE);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 64'd0);
        next_cycle();
        for (int h = 0; h < 2; h++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
            chk("bp_full_reqv", 64'(mem_req_valid_o), 64'd0);
            chk("bp_hold_v", 64'(out_valid_o), 64'd1);
            chk("bp_hold_pc", out_pc_o, BASE);
            chk("bp_hold_in", 64'(out_instr_o), 64'h13);
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("bp_pop0_pc", out_pc_o, BASE);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("bp_pop1_pc", out_pc_o, BASE + 64'd4);
        chk("bp_pop1_in", 64'(out_instr_o), 64'h0010_0093);
        chk("bp_resume_v", 64'(mem_req_valid_o), 64'd1);
        chk("bp_resume_a", mem_req_addr_o, BASE + 64'd8);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0020_0113, 1'b1, 1'b0, 64'd0);
        chk("bp_empty_v", 64'(out_valid_o), 64'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("bp_pop2_pc", out_pc_o, BASE + 64'd8);
        chk("bp_pop2_in", 64'(out_instr_o), 64'h0020_0113);
        next_cycle();

        // ---- redirect while in WAIT: next response dropped
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rw_addr", mem_req_addr_o, BASE + 64'hC);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_1000);
        chk("rw_reqv_redir", 64'(mem_req_valid_o), 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rw_drop_reqv", 64'(mem_req_valid_o), 64'd0);
        chk("rw_drop_outv", 64'(out_valid_o), 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rw_stale_outv", 64'(out_valid_o), 64'd0);
        chk("rw_new_addr", mem_req_addr_o, 64'h8000_1000);
        chk("rw_new_reqv", 64'(mem_req_valid_o), 64'd1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0030_0193, 1'b1, 1'b0, 64'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rw_out_pc", out_pc_o, 64'h8000_1000);
        chk("rw_out_in", 64'(out_instr_o), 64'h0030_0193);
        next_cycle();

        // ---- redirect with a handshake in the same cycle (unaligned target)
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_2002);
        chk("rh_reqv", 64'(mem_req_valid_o), 64'd1);
        chk("rh_addr", mem_req_addr_o, 64'h8000_1004);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 64'd0);
        chk("rh_drop_reqv", 64'(mem_req_valid_o), 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rh_stale_outv", 64'(out_valid_o), 64'd0);
        chk("rh_new_addr", mem_req_addr_o, 64'h8000_2000);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0213, 1'b1, 1'b0, 64'd0);
        next_cycle();
        // Hold the entry (out_ready=0) while the next request goes out.
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        chk("rh_out_pc", out_pc_o, 64'h8000_2000);
        chk("rh_out_in", 64'(out_instr_o), 64'h0040_0213);
        next_cycle();

        // ---- redirect + response in WAIT + pop, all in one cycle
        drive(1'b1, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 64'h8000_3000);
        chk("rrp_outv", 64'(out_valid_o), 64'd1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rrp_empty", 64'(out_valid_o), 64'd0);
        chk("rrp_reqv", 64'(mem_req_valid_o), 64'd1);
        chk("rrp_addr", mem_req_addr_o, 64'h8000_3000);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0050_0293, 1'b1, 1'b0, 64'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rrp_out_pc", out_pc_o, 64'h8000_3000);
        next_cycle();

        // ---- redirect from REQ with no handshake: new address next cycle
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_4000);
        chk("rq_reqv", 64'(mem_req_valid_o), 64'd1);
        chk("rq_old_addr", mem_req_addr_o, 64'h8000_3004);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rq_new_addr", mem_req_addr_o, 64'h8000_4000);
        next_cycle();

        // ---- reset for one cycle while in WAIT; late response ignored
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_reset_outputs("rst2");
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 32'h9999_9999, 1'b1, 1'b0, 64'd0);
        chk("rst2_reqv", 64'(mem_req_valid_o), 64'd1);
        chk("rst2_addr", mem_req_addr_o, BASE);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("rst2_late_outv", 64'(out_valid_o), 64'd0);
        chk("rst2_addr_hold", mem_req_addr_o, BASE);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 redirect_i  input  1  flush plus redirect, from the EX branch/jump resolution or the trap unit.
REQ-005 redirect_pc_i  input  64  new fetch address, sampled when redirect_i=1.
REQ-006 mem_req_valid_o  output  1  instruction-memory read request valid.
REQ-007 mem_req_ready_i  input  1  memory accepts the request.
REQ-008 mem_req_addr_o  output  64  request address, word aligned.
REQ-009 mem_rsp_valid_i  input  1  read data valid; there is no response back-pressure.
REQ-010 mem_rsp_data_i  input  32  instruction word.
REQ-011 out_valid_o  output  1  instruction available to the ID register.
REQ-012 out_ready_i  input  1  ID register accepts the instruction (ID stall_n).
REQ-013 out_pc_o  output  64  PC of the presented instruction.
REQ-014 out_instr_o  output  32  presented instruction.

Function
REQ-015 The block SHALL keep fetch_pc (64b), req_pc (64b), a 2-entry FIFO of {pc,instr}, a count (0..2), and a state in {REQ, WAIT, DROP}.
REQ-016 The block SHALL force fetch_pc[1:0]=0 on every load, so mem_req_addr_o = fetch_pc is always aligned.
REQ-017 mem_req_valid_o SHALL equal (state==REQ && count<2 && rst_n); it SHALL NOT depend combinationally on redirect_i.
REQ-018 On request handshake (valid && ready), the block SHALL set req_pc<=fetch_pc and fetch_pc<=fetch_pc+4 (64b wrap, no overflow flag), and go to WAIT.
REQ-019 At most one request SHALL be outstanding.
REQ-020 In WAIT, on mem_rsp_valid_i, the block SHALL push {req_pc, mem_rsp_data_i} and go to REQ.
REQ-021 Any response arriving in REQ state SHALL be ignored.
REQ-022 out_valid_o SHALL equal (count!=0); out_pc_o/out_instr_o SHALL show the FIFO head and hold stable while out_valid_o && !out_ready_i.
REQ-023 Pop SHALL occur on out_valid_o && out_ready_i; a push and a pop in the same cycle SHALL leave count unchanged and keep order.
REQ-024 Redirect (highest priority) SHALL: clear the FIFO (count<=0); set fetch_pc<=redirect_pc_i; and set the next state as follows.
  - REQ with no handshake -> REQ.
  - REQ with a handshake in the same cycle -> DROP.
  - WAIT without a response -> DROP.
  - WAIT with a response in the same cycle -> REQ; that response is not pushed.
  - DROP -> DROP.
REQ-025 In DROP, the next mem_rsp_valid_i SHALL be discarded and the state SHALL go to REQ.
REQ-026 A pop and a redirect in the same cycle SHALL leave count=0.
REQ-027 Latency: a response in cycle N SHALL give out_valid_o=1 in cycle N+1 when the FIFO was empty. A redirect in cycle N from REQ/no-handshake SHALL give mem_req_addr_o=redirect_pc_i in cycle N+1.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set state=REQ, fetch_pc=RESET_PC, req_pc=0, count=0, and FIFO contents=0.
REQ-029 During reset, mem_req_valid_o, out_valid_o, out_pc_o and out_instr_o SHALL be 0.
REQ-030 Reset asserted while a request is outstanding SHALL abandon it. A response arriving after reset, in REQ state, is ignored per REQ-021.

Verification
REQ-031 Release reset, ready=1, response 1 cycle after each handshake with data 0x00000013 -> requests at 0x80000000, 0x80000004, ...; out_pc_o follows the same sequence; no gaps beyond 1 request per 2 cycles.
REQ-032 Hold out_ready_i=0 -> count reaches 2, mem_req_valid_o drops to 0, head holds 0x80000000. Release -> both entries are delivered in order, then fetching resumes at 0x80000008.
REQ-033 Redirect to 0x80001000 while in WAIT -> the next response is discarded, FIFO is empty, the next request address is 0x80001000, and the first out_pc_o is 0x80001000.
REQ-034 Redirect in the same cycle as a request handshake -> DROP; the stale response is not delivered; the next request is at the redirect PC.
REQ-035 Redirect together with a response in WAIT, and with a pop -> count=0 and state REQ next cycle; the next request is issued immediately.
REQ-036 Assert rst_n=0 mid-WAIT for 1 cycle -> all outputs 0 during reset; the next request is at RESET_PC; the late response is ignored.
